pipeline_register_chain: RTL and testbench
==========================================

Name: pipeline_register_chain

Overview:
- Parametrised chain of DEPTH pipeline registers for the pipelined datapath. Register 0 sits nearest the fetch end; register DEPTH-1 feeds the last stage.
- Each register carries a WIDTH-bit payload and a valid bit.
- Per-register stall and flush controls. Stalls automatically freeze every younger register and insert bubbles downstream.
- Replaces hand-instantiated per-stage hold/clear registers and adds bubble tracking plus an idle-cycle counter.

Parameters:
- WIDTH, 32, payload bits per register
- DEPTH, 4, number of registers in the chain (>=2)
- CNT_W, 16, width of the idle-cycle counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  WIDTH  payload entering register 0
- valid_in  input  1  data_in is a real instruction
- stall  input  DEPTH  stall[i]=1: register i must hold this cycle
- flush  input  DEPTH  flush[i]=1: next value of registers 0..i is cleared
- count_clear  input  1  synchronous clear of idle_cycles
- stage_data  output  DEPTH*WIDTH  register i payload at bits [i*WIDTH +: WIDTH]
- stage_valid  output  DEPTH  valid bit of each register
- data_out  output  WIDTH  payload of register DEPTH-1
- valid_out  output  1  valid bit of register DEPTH-1
- idle_cycles  output  CNT_W  saturating count of cycles with valid_out=0

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - all payloads = 0, all valid = 0, idle_cycles = 0.
  - Takes effect immediately, independent of clk.
- Derived controls, combinational, for each i:
  - hold[i] = OR of stall[j] for j >= i. A downstream stall freezes all younger registers.
  - kill[i] = OR of flush[j] for j >= i.
- Next state of register i, in strict priority order:
  1. kill[i]: payload <= 0, valid <= 0. Flush beats stall.
  2. else hold[i]: payload and valid unchanged.
  3. else i == 0: payload <= data_in, valid <= valid_in.
  4. else hold[i-1] (i.e. stall[i-1] with register i free): bubble inserted, payload <= 0, valid <= 0.
  5. else: payload/valid <= register i-1 current payload/valid.
- Bubble payloads are all-zero so downstream decode sees a NOP-equivalent. Valid=0 is the authoritative marker.
- Flush[i] does not affect register i+1. It takes register i's current contents (the resolving instruction) unless itself killed or held.
- Simultaneous flush[i] and stall[k]:
  - k > i: registers 0..i are cleared; registers i+1..k hold.
  - k <= i: registers 0..i are cleared; the stall has no visible effect.
- Invalid entries advance exactly like valid ones. No bubble collapsing.
- Latency: an unstalled, unflushed input appears on data_out DEPTH cycles after sampling.
- Outputs are registered only. stage_*, data_out and valid_out have no combinational path from inputs.
- idle_cycles, evaluated on each clk edge:
  - count_clear=1: becomes 0. Clear beats increment.
  - else if valid_out == 0 (current value) and idle_cycles != all-ones: increments by 1.
  - Saturates at 2^CNT_W-1. No wrap.
- stall/flush bits wider than DEPTH do not exist. All DEPTH bits are significant, including stall[DEPTH-1], which freezes the whole chain.

Test Plan:
1. Reset/fill (DEPTH=4, WIDTH=32): assert reset mid-cycle, release, then feed 0x11,0x22,0x33,0x44,0x55 with valid_in=1 and no stall -> all outputs 0 during reset; data_out=0x11 valid_out=1 on the 4th edge after the first sample, then 0x22..0x55 on consecutive cycles; idle_cycles=4 when 0x11 emerges.
2. Stall bubble: chain holds A,B,C,D (reg0..3), assert stall[1] for 2 cycles -> reg0=A', reg1=B held both cycles; reg2 gets bubble (valid 0, payload 0) for 2 cycles; reg3 drains C then bubble; after release B moves to reg2.
3. Flush: chain holds A,B,C,D, pulse flush[1] with valid_in=1 data_in=0x99 -> next cycle reg0,reg1 valid=0 payload=0; reg2=B, reg3=C; 0x99 discarded.
4. Flush beats stall: assert stall[2] and flush[2] together -> regs 0..2 cleared, reg3 takes reg2 old contents; same cycle with stall[3]+flush[1] -> reg3,reg2 hold, reg0,reg1 cleared.
5. Counter: CNT_W=4, valid_in=0 for 20 cycles -> idle_cycles saturates at 15 and stays; count_clear for 1 cycle -> 0, then resumes counting from 1.
6. Async reset mid-operation: assert reset between edges while stall[3]=1 and the chain is full -> all stage_valid drop to 0 before the next edge; first edge after release loads data_in into reg0 only.

Source files
------------

// File: rtl/pipeline_register_chain_if.sv
// Bus bundle for pipeline_register_chain: upstream payload, per-stage controls,
// and the registered stage view that the chain drives back.
interface pipeline_register_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0]       data_in;
    logic                   valid_in;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic                   count_clear;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]       stage_valid;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic [CNT_W-1:0]       idle_cycles;

    modport master (
        output data_in, valid_in, stall, flush, count_clear,
        input  stage_data, stage_valid, data_out, valid_out, idle_cycles
    );

    modport slave (
        input  data_in, valid_in, stall, flush, count_clear,
        output stage_data, stage_valid, data_out, valid_out, idle_cycles
    );
endinterface

// File: rtl/pipeline_register_chain.sv
// Chain of DEPTH payload/valid pipeline registers with per-stage stall and flush,
// automatic bubble insertion below a stall, and a saturating idle-cycle counter.
module pipeline_register_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic                       clk,
    input logic                       reset,
    pipeline_register_chain_if.slave  bus
);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] kill;

    logic [WIDTH-1:0] payload_q [DEPTH];
    logic [WIDTH-1:0] payload_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CNT_W-1:0] idle_q;
    logic [CNT_W-1:0] idle_d;

    // hold[i]/kill[i] are true when any stage at or below i stalls/flushes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hold[i] = |(bus.stall >> i);
            kill[i] = |(bus.flush >> i);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        for (int i = 0; i < DEPTH; i++) begin
            payload_d[i] = payload_q[i];
            valid_d[i]   = valid_q[i];
        end

        if (kill[0]) begin
            payload_d[0] = '0;
            valid_d[0]   = 1'b0;
        end else if (!hold[0]) begin
            payload_d[0] = bus.data_in;
            valid_d[0]   = bus.valid_in;
        end

        // A killed upstream stage is not really holding, so its current
        // contents still drain into the next stage instead of a bubble.
        for (int i = 1; i < DEPTH; i++) begin
            if (kill[i]) begin
                payload_d[i] = '0;
                valid_d[i]   = 1'b0;
            end else if (!hold[i]) begin
                if (hold[i-1] && !kill[i-1]) begin
                    payload_d[i] = '0;
                    valid_d[i]   = 1'b0;
                end else begin
                    payload_d[i] = payload_q[i-1];
                    valid_d[i]   = valid_q[i-1];
                end
            end
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (bus.count_clear) begin
            idle_d = '0;
        end else if (!valid_q[DEPTH-1] && (idle_q != {CNT_W{1'b1}})) begin
            idle_d = idle_q + CNT_W'(1);
        end
    end

    // NOTE: the payload array is reset element by element because a flushed
    // or reset stage must present an all-zero NOP payload, not stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
            end
            valid_q <= '0;
            idle_q  <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // stage samples its neighbour's pre-edge value.
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= payload_d[i];
            end
            valid_q <= valid_d;
            idle_q  <= idle_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage_out
        assign bus.stage_data[g*WIDTH +: WIDTH] = payload_q[g];
    end

    assign bus.stage_valid = valid_q;
    assign bus.data_out    = payload_q[DEPTH-1];
    assign bus.valid_out   = valid_q[DEPTH-1];
    assign bus.idle_cycles = idle_q;

endmodule

// File: tb/tb_pipeline_register_chain.sv
// Directed bench for pipeline_register_chain (DEPTH=4, WIDTH=32, CNT_W=4):
// fill, stall bubbles, flush, flush-vs-stall, counter saturation, async reset.
module tb_pipeline_register_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipeline_register_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pipeline_register_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] sd(input int i);
        return bus.stage_data[i*WIDTH +: WIDTH];
    endfunction

    initial begin
        reset           = 1'b0;
        bus.data_in     = '0;
        bus.valid_in    = 1'b0;
        bus.stall       = '0;
        bus.flush       = '0;
        bus.count_clear = 1'b0;

        // Reset asserted between edges, then released mid-cycle.
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 64'(bus.stage_valid), 64'h0);
        check("rst_data", 64'(bus.stage_data), 64'h0);
        check("rst_dout", 64'(bus.data_out), 64'h0);
        check("rst_vout", 64'(bus.valid_out), 64'h0);
        check("rst_idle", 64'(bus.idle_cycles), 64'h0);
        tick();
        tick();
        reset = 1'b0;

        // Fill: 0x11 reaches data_out on the 4th edge with idle_cycles=4.
        bus.valid_in = 1'b1;
        bus.data_in = 32'h11; tick();
        check("fill_r0", 64'(sd(0)), 64'h11);
        bus.data_in = 32'h22; tick();
        bus.data_in = 32'h33; tick();
        check("fill_vout_early", 64'(bus.valid_out), 64'h0);
        bus.data_in = 32'h44; tick();
        check("fill_dout_11", 64'(bus.data_out), 64'h11);
        check("fill_vout_11", 64'(bus.valid_out), 64'h1);
        check("fill_idle_4", 64'(bus.idle_cycles), 64'h4);
        bus.data_in = 32'h55; tick();
        check("fill_dout_22", 64'(bus.data_out), 64'h22);
        check("fill_idle_hold", 64'(bus.idle_cycles), 64'h4);

        // Stall bubble: chain A=55,B=44,C=33,D=22; stall[1] for two cycles.
        bus.data_in = 32'h66;
        bus.stall   = 4'b0010;
        tick();
        check("stl1_r0", 64'(sd(0)), 64'h55);
        check("stl1_r1", 64'(sd(1)), 64'h44);
        check("stl1_r2", 64'(sd(2)), 64'h0);
        check("stl1_valid", 64'(bus.stage_valid), 64'b1011);
        check("stl1_dout", 64'(bus.data_out), 64'h33);
        tick();
        check("stl2_r1", 64'(sd(1)), 64'h44);
        check("stl2_dout", 64'(bus.data_out), 64'h0);
        check("stl2_valid", 64'(bus.stage_valid), 64'b0011);
        bus.stall = '0;
        tick();
        check("stl_rel_r2", 64'(sd(2)), 64'h44);
        check("stl_rel_r0", 64'(sd(0)), 64'h66);
        check("stl_rel_valid", 64'(bus.stage_valid), 64'b0111);

        // Flush[1]: chain A=77,B=66,C=55,D=44; incoming 0x99 is discarded.
        bus.data_in = 32'h77; tick();
        check("fl_pre_valid", 64'(bus.stage_valid), 64'b1111);
        bus.data_in = 32'h99;
        bus.flush   = 4'b0010;
        tick();
        check("fl_r0", 64'(sd(0)), 64'h0);
        check("fl_r1", 64'(sd(1)), 64'h0);
        check("fl_r2", 64'(sd(2)), 64'h66);
        check("fl_r3", 64'(sd(3)), 64'h55);
        check("fl_valid", 64'(bus.stage_valid), 64'b1100);
        bus.flush = '0;

        // Refill A1..A4, then stall[2]+flush[2]: reg3 takes reg2's A2.
        bus.data_in = 32'hA1; tick();
        bus.data_in = 32'hA2; tick();
        bus.data_in = 32'hA3; tick();
        bus.data_in = 32'hA4; tick();
        check("ref_a_dout", 64'(bus.data_out), 64'hA1);
        bus.data_in = 32'hB1;
        bus.stall   = 4'b0100;
        bus.flush   = 4'b0100;
        tick();
        check("fs22_valid", 64'(bus.stage_valid), 64'b1000);
        check("fs22_dout", 64'(bus.data_out), 64'hA2);
        check("fs22_r2", 64'(sd(2)), 64'h0);

        // Refill C1..C4, then stall[3]+flush[1]: reg2/reg3 hold, reg0/reg1 clear.
        bus.stall = '0;
        bus.flush = '0;
        bus.data_in = 32'hC1; tick();
        bus.data_in = 32'hC2; tick();
        bus.data_in = 32'hC3; tick();
        bus.data_in = 32'hC4; tick();
        bus.data_in = 32'hD1;
        bus.stall   = 4'b1000;
        bus.flush   = 4'b0010;
        tick();
        check("fs31_r3", 64'(sd(3)), 64'hC1);
        check("fs31_r2", 64'(sd(2)), 64'hC2);
        check("fs31_r1", 64'(sd(1)), 64'h0);
        check("fs31_valid", 64'(bus.stage_valid), 64'b1100);

        // Counter: clear, then idle input until saturation at 15.
        bus.stall       = '0;
        bus.flush       = '0;
        bus.valid_in    = 1'b0;
        bus.data_in     = '0;
        bus.count_clear = 1'b1;
        tick();
        check("cnt_clr0", 64'(bus.idle_cycles), 64'h0);
        bus.count_clear = 1'b0;
        tick();
        check("cnt_vout_busy", 64'(bus.idle_cycles), 64'h0);
        for (int i = 0; i < 9; i++) tick();
        check("cnt_9", 64'(bus.idle_cycles), 64'h9);
        for (int i = 0; i < 10; i++) tick();
        check("cnt_sat", 64'(bus.idle_cycles), 64'hF);
        tick();
        check("cnt_no_wrap", 64'(bus.idle_cycles), 64'hF);
        bus.count_clear = 1'b1;
        tick();
        check("cnt_clr_sat", 64'(bus.idle_cycles), 64'h0);
        bus.count_clear = 1'b0;
        tick();
        check("cnt_resume", 64'(bus.idle_cycles), 64'h1);

        // Async reset while the full chain is stalled by stall[3].
        bus.valid_in = 1'b1;
        bus.data_in = 32'hE1; tick();
        bus.data_in = 32'hE2; tick();
        bus.data_in = 32'hE3; tick();
        bus.data_in = 32'hE4; tick();
        bus.stall = 4'b1000;
        tick();
        check("ar_held_dout", 64'(bus.data_out), 64'hE1);
        check("ar_full", 64'(bus.stage_valid), 64'b1111);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", 64'(bus.stage_valid), 64'h0);
        check("ar_data", 64'(bus.stage_data), 64'h0);
        check("ar_idle", 64'(bus.idle_cycles), 64'h0);
        #1 reset = 1'b0;
        bus.stall   = '0;
        bus.data_in = 32'hF1;
        tick();
        check("ar_first_valid", 64'(bus.stage_valid), 64'b0001);
        check("ar_first_r0", 64'(sd(0)), 64'hF1);
        check("ar_first_r1", 64'(sd(1)), 64'h0);
        check("ar_first_idle", 64'(bus.idle_cycles), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
